// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer:
// FSM state encoding and the signed branch-offset table.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int TABLE_DEPTH = 8;
    localparam int SEL_W       = 3;

    localparam int TGT_0 = 2;
    localparam int TGT_1 = 15;
    localparam int TGT_2 = 50;
    localparam int TGT_3 = -41;
    localparam int TGT_4 = 354;
    localparam int TGT_5 = -358;
    localparam int TGT_6 = 398;
    localparam int TGT_7 = -408;

    function automatic int target_offset(input logic [SEL_W-1:0] sel);
        int value;
        value = 0;
        case (sel)
            3'd0: value = TGT_0;
            3'd1: value = TGT_1;
            3'd2: value = TGT_2;
            3'd3: value = TGT_3;
            3'd4: value = TGT_4;
            3'd5: value = TGT_5;
            3'd6: value = TGT_6;
            3'd7: value = TGT_7;
            default: value = 0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/pc_sequencer_branch_target_rom.sv
// Combinational lookup of the branch target table, sign-extended to the PC width.
module branch_target_rom
    import pc_pkg::*;
#(
    parameter int D = 12
) (
    input  logic [SEL_W-1:0]    sel,
    output logic signed [D-1:0] target
);

    logic [D-1:0] table_mem [TABLE_DEPTH];

    // Truncating the 32-bit constant keeps its two's-complement pattern at D bits.
    for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_table
        assign table_mem[gi] = D'(target_offset(SEL_W'(gi)));
    end

    assign target = $signed(table_mem[sel]);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: IDLE/RUN/HALT control, branch redirection through
// the target table, and saturating instruction and cycle counters.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [D-1:0]     prog_ctr,
    input  logic             branch_en,
    input  logic             branch_cond,
    input  logic [SEL_W-1:0] branch_sel,
    input  logic             branch_abs,
    input  logic             halt_req,
    output logic             branch_taken,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    instr_count,
    output logic [CW-1:0]    cycle_count
);

    state_t              state_reg;
    logic signed [D-1:0] target;
    logic                accept;
    logic                take_branch;
    logic [D-1:0]        branch_pc;
    logic [CW-1:0]       instr_next;
    logic [CW-1:0]       cycle_next;

    branch_target_rom #(.D(D)) u_rom (
        .sel    (branch_sel),
        .target (target)
    );

    always_comb begin
        accept      = fetch_valid && fetch_ready;
        take_branch = branch_en && branch_cond;
        branch_pc   = branch_abs ? D'($unsigned(target)) : D'(prog_ctr + $unsigned(target));
        // Counters stick at all-ones rather than wrapping.
        instr_next  = (instr_count == '1) ? instr_count : instr_count + CW'(1);
        cycle_next  = (cycle_count == '1) ? cycle_count : cycle_count + CW'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            prog_ctr     <= '0;
            instr_count  <= '0;
            cycle_count  <= '0;
            fetch_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_reg   <= RUN;
                        prog_ctr    <= '0;
                        instr_count <= '0;
                        cycle_count <= '0;
                        fetch_valid <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_next;
                    if (accept) begin
                        instr_count <= instr_next;
                        if (halt_req) begin
                            // PC stays on the halt instruction for inspection.
                            state_reg   <= HALT;
                            fetch_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else if (take_branch) begin
                            prog_ctr     <= branch_pc;
                            branch_taken <= 1'b1;
                        end else begin
                            prog_ctr <= prog_ctr + D'(1);
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    fetch_valid <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the 9-bit CPU fetch stage. Owns the PC and steps it by one per accepted instruction. Resolves taken branches through an internal 8-entry target table, either PC-relative or absolute. Provides a valid/ready fetch handshake to instruction memory, start/halt control toward the test harness, and saturating instruction/cycle counters.

Parameters:
D, 12, PC width in bits; instruction address space is 2^D words
CW, 16, width of instr_count and cycle_count

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-low reset
start  input  1  begin program at PC 0; honoured in IDLE and HALT only
fetch_valid  output  1  prog_ctr holds a valid fetch address
fetch_ready  input  1  instruction memory accepts the address this cycle
prog_ctr  output  D  current PC
branch_en  input  1  accepted instruction is a conditional branch
branch_cond  input  1  branch condition flag from ALU
branch_sel  input  3  target-table index
branch_abs  input  1  1 = absolute target, 0 = PC-relative
halt_req  input  1  accepted instruction is the done/halt instruction
branch_taken  output  1  one-cycle pulse, registered, when a branch redirects the PC
busy  output  1  high in RUN
done  output  1  high in HALT; stays high until start or reset
instr_count  output  CW  accepted instructions since start, saturating
cycle_count  output  CW  cycles spent in RUN since start, saturating

Behaviour:
- States: IDLE, RUN, HALT.
- Reset (Reset==0 at an edge, in any state, including mid-RUN): state=IDLE, prog_ctr=0, counters=0. All 1-bit outputs are 0.
- IDLE: start=1 -> RUN with prog_ctr=0 and counters cleared. Otherwise hold.
- RUN: fetch_valid=1 and busy=1. Accept = fetch_valid && fetch_ready.
- branch_en, branch_cond, branch_sel, branch_abs and halt_req are sampled only on accept cycles. They are ignored otherwise.
- Per accept, priority order:
  - halt_req=1 -> HALT. prog_ctr is held at the halt instruction. instr_count increments.
  - Otherwise branch_en && branch_cond -> prog_ctr = branch_abs ? T : (prog_ctr + T) mod 2^D. branch_taken=1 next cycle.
  - Otherwise prog_ctr = (prog_ctr + 1) mod 2^D.
- No accept: prog_ctr held. Wait cycles are unbounded.
- cycle_count increments every RUN cycle, including wait cycles. instr_count increments per accept. Both saturate at all-ones and never wrap.
- start while in RUN is ignored.
- HALT: fetch_valid=0, done=1. Counters frozen and readable. start=1 -> RUN with prog_ctr=0, counters cleared and done=0 on the same edge.
- Target table, signed, sign-extended to D bits:
  - 0:+2, 1:+15, 2:+50, 3:-41
  - 4:+354, 5:-358, 6:+398, 7:-408
- Absolute mode uses the D-bit two's-complement pattern as an unsigned address.
- Relative adds are modulo 2^D. No overflow flag. Wrap below 0 and above 2^D-1 is legal.
- Fetch latency: the address is presented combinationally from the registered PC. The next PC is visible one cycle after accept.

Decomposition:
- Shared package pc_pkg holds:
  - the state enum typedef (IDLE, RUN, HALT)
  - localparam for table depth 8
  - the 8 signed target constants
- One sub-module, branch_target_rom: 3-bit index in, D-bit signed target out, purely combinational.
- pc_sequencer instantiates branch_target_rom and holds the FSM, PC register and counters.

Test Plan:
- Linear fetch: Reset, then start, then fetch_ready=1 for 4 cycles with no branches -> prog_ctr 0,1,2,3,4; instr_count=4; cycle_count=4; busy=1.
- Relative wrap: at PC=10, accept with branch_en=1, branch_cond=1, branch_sel=3, branch_abs=0 -> prog_ctr=4065 and branch_taken pulses once. Same at PC=4090 with sel=1 -> 9. Repeat with branch_cond=0 -> PC+1 and no pulse.
- Absolute: branch_abs=1 with sel=4 -> 354; with sel=5 -> 3738; with sel=7 -> 3688.
- Stall: fetch_ready=0 for 3 cycles at PC=7 with branch_en=1, branch_cond=1 driven -> prog_ctr stays 7, instr_count unchanged, cycle_count +3, no branch_taken. The next accept applies the branch.
- Halt priority and restart: halt_req=1 and taken branch on the same accept at PC=20 -> HALT, prog_ctr=20, done=1, fetch_valid=0, counters frozen. Then start -> prog_ctr=0, done=0, counters=0.
- Reset mid-run and saturation: Reset low for one edge in RUN at PC=33 -> IDLE, all outputs 0. With CW=4, 20 RUN cycles -> cycle_count holds at 15.
